// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with rts_n flow control, overflow and frame-error statistics
module uart_rx_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_frame_error,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  rts_n,
    output logic                  overflow,
    output logic [7:0]            drop_count,
    output logic [7:0]            frame_err_count,
    input  logic                  clear_stats
);
    localparam int                DEPTH_INT = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH+1)'(DEPTH_INT);
    localparam logic [ADDR_WIDTH:0] AFULL   = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH_INT];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            drop_count_q, drop_count_d;
    logic [7:0]            frame_err_count_q, frame_err_count_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rts_n_q, rts_n_d;

    logic full, push, pop, drop, fe_rise;

    assign s_axis_tready   = 1'b1;
    assign m_axis_tvalid   = (level_q != '0);
    assign m_axis_tdata    = mem_q[rd_ptr_q];
    assign level           = level_q;
    assign rts_n           = rts_n_q;
    assign overflow        = overflow_q;
    assign drop_count      = drop_count_q;
    assign frame_err_count = frame_err_count_q;

    always_comb begin
        full    = (level_q == DEPTH);
        pop     = m_axis_tvalid & m_axis_tready;
        // A full FIFO still accepts a byte when a slot frees in the same cycle.
        push    = s_axis_tvalid & (~full | pop);
        drop    = s_axis_tvalid & full & ~pop;
        fe_rise = s_frame_error & ~frame_err_q;

        wr_ptr_d          = push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d          = pop  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        level_d           = level_q;
        overflow_d        = overflow_q;
        drop_count_d      = drop_count_q;
        frame_err_count_d = frame_err_count_q;
        frame_err_d       = s_frame_error;

        if (push && !pop) begin
            level_d = level_q + (ADDR_WIDTH+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (ADDR_WIDTH+1)'(1);
        end

        // Clear first, then apply this cycle's events so a coincident event survives.
        if (clear_stats) begin
            overflow_d        = 1'b0;
            drop_count_d      = 8'd0;
            frame_err_count_d = 8'd0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_d != 8'hFF) begin
                drop_count_d = drop_count_d + 8'd1;
            end
        end
        if (fe_rise && frame_err_count_d != 8'hFF) begin
            frame_err_count_d = frame_err_count_d + 8'd1;
        end

        rts_n_d = (level_d >= AFULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            level_q           <= '0;
            overflow_q        <= 1'b0;
            drop_count_q      <= 8'd0;
            frame_err_count_q <= 8'd0;
            frame_err_q       <= 1'b0;
            rts_n_q           <= 1'b0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            level_q           <= level_d;
            overflow_q        <= overflow_d;
            drop_count_q      <= drop_count_d;
            frame_err_count_q <= frame_err_count_d;
            frame_err_q       <= frame_err_d;
            rts_n_q           <= rts_n_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       s_frame_error = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic [4:0] level;
    logic       rts_n;
    logic       overflow;
    logic [7:0] drop_count;
    logic [7:0] frame_err_count;
    logic       clear_stats = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_fifo dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_frame_error(s_frame_error),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .level(level), .rts_n(rts_n), .overflow(overflow),
        .drop_count(drop_count), .frame_err_count(frame_err_count), .clear_stats(clear_stats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a queue of bytes plus plain counters.
    logic [7:0] mq[$];
    bit         m_live = 0;
    bit         m_ovf;
    int         m_drop, m_fe, m_rts;
    bit         m_fe_prev;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_ovf = 0; m_drop = 0; m_fe = 0; m_rts = 0; m_fe_prev = 0;
                m_live = 1;
            end else begin
                bit do_pop, is_full, do_push, do_drop;
                do_pop  = (mq.size() != 0) && m_axis_tready;
                is_full = (mq.size() == 16);
                do_push = s_axis_tvalid && (!is_full || do_pop);
                do_drop = s_axis_tvalid && is_full && !do_pop;
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back(s_axis_tdata);
                if (clear_stats) begin m_ovf = 0; m_drop = 0; m_fe = 0; end
                if (do_drop) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
                if (s_frame_error && !m_fe_prev && m_fe < 255) m_fe++;
                m_fe_prev = s_frame_error;
                m_rts = (mq.size() >= 12) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmp_level", 32'(level), 32'(mq.size()));
            chk("cmp_tvalid", 32'(m_axis_tvalid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("cmp_tdata", 32'(m_axis_tdata), 32'(mq[0]));
            chk("cmp_rts_n", 32'(rts_n), 32'(m_rts));
            chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
            chk("cmp_drop_count", 32'(drop_count), 32'(m_drop));
            chk("cmp_fe_count", 32'(frame_err_count), 32'(m_fe));
            chk("cmp_tready", 32'(s_axis_tready), 32'd1);
        end
    end

    initial begin
        tick(); tick();
        chk("rst_level", 32'(level), 0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_rts_n", 32'(rts_n), 0);
        chk("rst_tready", 32'(s_axis_tready), 1);
        chk("rst_counts", 32'({overflow, drop_count, frame_err_count}), 0);
        rst = 1'b0;
        tick();

        // Single byte into an empty FIFO
        s_axis_tdata = 8'h55; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        chk("one_tvalid", 32'(m_axis_tvalid), 1);
        chk("one_tdata", 32'(m_axis_tdata), 32'h55);
        chk("one_level", 32'(level), 1);
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        chk("one_drained", 32'(level), 0);

        // Fill 0x00..0x0F, watching rts_n, then drain in order
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata = 8'(i); s_axis_tvalid = 1'b1;
            tick();
            chk("fill_level", 32'(level), 32'(i + 1));
            chk("fill_rts_n", 32'(rts_n), 32'(i + 1 >= 12));
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_order", 32'(m_axis_tdata), 32'(i));
            tick();
            chk("drain_rts_n", 32'(rts_n), 32'(15 - i >= 12));
        end
        m_axis_tready = 1'b0;
        chk("drain_empty", 32'(m_axis_tvalid), 0);

        // Full FIFO drops three bytes
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata = 8'(8'h10 + i); s_axis_tvalid = 1'b1;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata = 8'(8'hE0 + i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drop_count", 32'(drop_count), 3);
        chk("ovf_level", 32'(level), 16);
        chk("ovf_head", 32'(m_axis_tdata), 32'h10);

        // Push and pop together while full
        s_axis_tdata = 8'hAA; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        chk("pp_level", 32'(level), 16);
        chk("pp_drop_count", 32'(drop_count), 3);
        for (int i = 0; i < 16; i++) begin
            chk("pp_drain", 32'(m_axis_tdata), (i == 15) ? 32'hAA : 32'(8'h11 + i));
            tick();
        end
        m_axis_tready = 1'b0;
        chk("pp_empty", 32'(level), 0);

        // Frame-error counter saturates
        for (int i = 0; i < 300; i++) begin
            s_frame_error = 1'b1; tick();
            s_frame_error = 1'b0; tick();
        end
        chk("fe_saturate", 32'(frame_err_count), 255);

        // clear_stats coincident with a drop
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata = 8'(8'h30 + i); s_axis_tvalid = 1'b1;
            tick();
        end
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0; s_axis_tvalid = 1'b0;
        chk("clr_drop_count", 32'(drop_count), 1);
        chk("clr_overflow", 32'(overflow), 1);
        chk("clr_fe_count", 32'(frame_err_count), 0);
        chk("clr_level", 32'(level), 16);

        // Reset mid-operation at level 7
        m_axis_tready = 1'b1;
        repeat (9) tick();
        m_axis_tready = 1'b0;
        chk("pre_rst_level", 32'(level), 7);
        chk("pre_rst_head", 32'(m_axis_tdata), 32'h39);
        rst = 1'b1;
        tick();
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("mid_rst_counts", 32'({overflow, drop_count, frame_err_count}), 0);
        chk("mid_rst_rts_n", 32'(rts_n), 0);
        rst = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
